// File: rtl/epd_pkg.sv
// Shared state encodings, field constants and helpers for the Ethernet packet detector.
package epd_pkg;

    typedef logic [2:0] epd_state_t;

    localparam epd_state_t IDLE = 3'd0;
    localparam epd_state_t PRE  = 3'd1;
    localparam epd_state_t DST  = 3'd2;
    localparam epd_state_t SRC  = 3'd3;
    localparam epd_state_t TL   = 3'd4;
    localparam epd_state_t PAY  = 3'd5;
    localparam epd_state_t ERR  = 3'd6;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam int unsigned ADDR_BYTES    = 6;
    localparam int unsigned TL_BYTES      = 2;
    localparam int unsigned MAX_LENGTH    = 1500;
    localparam int unsigned MIN_TYPE      = 1536;

    // Values 1501..1535 are neither a legal length nor a legal EtherType.
    function automatic logic tl_ok(input logic [15:0] v);
        return (v <= 16'(MAX_LENGTH)) || (v >= 16'(MIN_TYPE));
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/epd_field_shift.sv
// N-byte MSB-first capture register with byte counter; value_o already includes the current byte
// so the caller can judge a field on the same edge its last byte arrives.
module epd_field_shift #(
    parameter int unsigned NUM_BYTES = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   shift_i,
    input  logic [7:0]             data_i,
    output logic [8*NUM_BYTES-1:0] value_o,
    output logic                   last_o,
    output logic                   done_o
);

    localparam int unsigned W  = 8 * NUM_BYTES;
    localparam int unsigned CW = $clog2(NUM_BYTES + 1);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        value_o = (value_q << 8) | W'(data_i);
        last_o  = shift_i && !done_q && (cnt_q == CW'(NUM_BYTES - 1));
        value_d = value_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (clear_i) begin
            value_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (shift_i && !done_q) begin
            value_d = value_o;
            cnt_d   = cnt_q + CW'(1);
            done_d  = last_o;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/epd_fsm.sv
// Ethernet packet detector: parses preamble/DST/SRC/TL/payload and counts well-formed frames.
// Optional EPD_LENGTH_CHECK_EN: payload must be at least as long as a length-type TL field.
module epd_fsm
    import epd_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned MIN_FRAME    = 64,
    parameter int unsigned MAX_FRAME    = 1518
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       control,
    output logic       preamble_valid,
    output logic       dst_addr_valid,
    output logic       src_addr_valid,
    output logic       type_length_valid,
    output logic       packet_size_valid,
    output logic [3:0] valid_packet_counter
);

    localparam int unsigned PW = $clog2(PREAMBLE_LEN + 1);

    epd_state_t  state_q, state_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [10:0] size_q, size_d;
    logic        pre_v_q, pre_v_d;
    logic        dst_v_q, dst_v_d;
    logic        src_v_q, src_v_d;
    logic        tl_v_q, tl_v_d;
    logic        pulse_q, pulse_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        len_ok;
`ifdef EPD_LENGTH_CHECK_EN
    logic [10:0] pay_q, pay_d;
    logic [15:0] tl_len_q, tl_len_d;
`endif

    logic        field_clear;
    logic [8*ADDR_BYTES-1:0] dst_value, src_value;
    logic [8*TL_BYTES-1:0]   tl_value;
    logic        dst_last, src_last, tl_last;
    logic        dst_done, src_done, tl_done;
    logic        dst_shift, src_shift, tl_shift;

    assign field_clear = (state_q == IDLE);
    assign dst_shift   = control && (state_q == DST) && !dst_done;
    assign src_shift   = control && (state_q == SRC) && !src_done;
    assign tl_shift    = control && (state_q == TL) && !tl_done;

    epd_field_shift #(.NUM_BYTES(ADDR_BYTES)) u_dst (
        .clock   (clock),
        .reset   (reset),
        .clear_i (field_clear),
        .shift_i (dst_shift),
        .data_i  (data),
        .value_o (dst_value),
        .last_o  (dst_last),
        .done_o  (dst_done)
    );

    epd_field_shift #(.NUM_BYTES(ADDR_BYTES)) u_src (
        .clock   (clock),
        .reset   (reset),
        .clear_i (field_clear),
        .shift_i (src_shift),
        .data_i  (data),
        .value_o (src_value),
        .last_o  (src_last),
        .done_o  (src_done)
    );

    epd_field_shift #(.NUM_BYTES(TL_BYTES)) u_tl (
        .clock   (clock),
        .reset   (reset),
        .clear_i (field_clear),
        .shift_i (tl_shift),
        .data_i  (data),
        .value_o (tl_value),
        .last_o  (tl_last),
        .done_o  (tl_done)
    );

`ifdef EPD_LENGTH_CHECK_EN
    assign len_ok = (tl_len_q > 16'(MAX_LENGTH)) || ({5'd0, pay_q} >= tl_len_q);
`else
    assign len_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        size_d    = size_q;
        pre_v_d   = pre_v_q;
        dst_v_d   = dst_v_q;
        src_v_d   = src_v_q;
        tl_v_d    = tl_v_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;
`ifdef EPD_LENGTH_CHECK_EN
        pay_d     = pay_q;
        tl_len_d  = tl_len_q;
`endif
        case (state_q)
            IDLE: begin
                pre_cnt_d = '0;
                size_d    = '0;
`ifdef EPD_LENGTH_CHECK_EN
                pay_d     = '0;
                tl_len_d  = '0;
`endif
                if (control) begin
                    if (data == PREAMBLE_BYTE) begin
                        pre_cnt_d = PW'(1);
                        if (PREAMBLE_LEN == 1) begin
                            pre_v_d = 1'b1;
                            state_d = DST;
                        end else begin
                            state_d = PRE;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            PRE: begin
                if (!control) begin
                    state_d = IDLE;
                end else if (data != PREAMBLE_BYTE) begin
                    state_d = ERR;
                end else begin
                    pre_cnt_d = pre_cnt_q + PW'(1);
                    if (pre_cnt_q == PW'(PREAMBLE_LEN - 1)) begin
                        pre_v_d = 1'b1;
                        state_d = DST;
                    end
                end
            end
            DST: begin
                if (!control) begin
                    state_d = IDLE;
                end else begin
                    size_d = sat_inc11(size_q);
                    if (dst_last) begin
                        if (dst_value != '0) begin
                            dst_v_d = 1'b1;
                            state_d = SRC;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            SRC: begin
                if (!control) begin
                    state_d = IDLE;
                end else begin
                    size_d = sat_inc11(size_q);
                    if (src_last) begin
                        if ((src_value != '0) && (src_value != '1)) begin
                            src_v_d = 1'b1;
                            state_d = TL;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            TL: begin
                if (!control) begin
                    state_d = IDLE;
                end else begin
                    size_d = sat_inc11(size_q);
                    if (tl_last) begin
                        if (tl_ok(tl_value)) begin
                            tl_v_d  = 1'b1;
                            state_d = PAY;
`ifdef EPD_LENGTH_CHECK_EN
                            tl_len_d = tl_value;
`endif
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            PAY: begin
                if (control) begin
                    size_d = sat_inc11(size_q);
`ifdef EPD_LENGTH_CHECK_EN
                    pay_d  = sat_inc11(pay_q);
`endif
                end else begin
                    state_d = IDLE;
                    if ((size_q >= 11'(MIN_FRAME)) && (size_q <= 11'(MAX_FRAME)) && len_ok) begin
                        pulse_d = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            ERR: begin
                if (!control) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Field flags are held for the whole frame and dropped together on the return to IDLE.
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            pre_v_d = 1'b0;
            dst_v_d = 1'b0;
            src_v_d = 1'b0;
            tl_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            size_q    <= '0;
            pre_v_q   <= 1'b0;
            dst_v_q   <= 1'b0;
            src_v_q   <= 1'b0;
            tl_v_q    <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
`ifdef EPD_LENGTH_CHECK_EN
            pay_q     <= '0;
            tl_len_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            size_q    <= size_d;
            pre_v_q   <= pre_v_d;
            dst_v_q   <= dst_v_d;
            src_v_q   <= src_v_d;
            tl_v_q    <= tl_v_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
`ifdef EPD_LENGTH_CHECK_EN
            pay_q     <= pay_d;
            tl_len_q  <= tl_len_d;
`endif
        end
    end

    assign preamble_valid       = pre_v_q;
    assign dst_addr_valid       = dst_v_q;
    assign src_addr_valid       = src_v_q;
    assign type_length_valid    = tl_v_q;
    assign packet_size_valid    = pulse_q;
    assign valid_packet_counter = cnt_q;

endmodule

// File: tb/tb_epd_fsm.sv
// Directed bench for epd_fsm: header/error/size cases, reset abort and counter wrap.
module tb_epd_fsm;

    logic       clock;
    logic       reset;
    logic [7:0] data;
    logic       control;
    logic       preamble_valid;
    logic       dst_addr_valid;
    logic       src_addr_valid;
    logic       type_length_valid;
    logic       packet_size_valid;
    logic [3:0] valid_packet_counter;

    int         n_cmp = 0;
    int         n_err = 0;
    int         seen_pulses = 0;
    int         exp_pulses = 0;
    logic [3:0] exp_cnt = 4'd0;

    localparam logic [47:0] DST_OK  = 48'h0102_0304_0506;
    localparam logic [47:0] SRC_OK  = 48'hFFFE_FDFC_FBFA;
    localparam logic [47:0] ZERO48  = 48'h0;
    localparam logic [47:0] ONES48  = 48'hFFFF_FFFF_FFFF;

    epd_fsm dut (
        .clock                (clock),
        .reset                (reset),
        .data                 (data),
        .control              (control),
        .preamble_valid       (preamble_valid),
        .dst_addr_valid       (dst_addr_valid),
        .src_addr_valid       (src_addr_valid),
        .type_length_valid    (type_length_valid),
        .packet_size_valid    (packet_size_valid),
        .valid_packet_counter (valid_packet_counter)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Each cycle high counts separately, so a stretched pulse shows up as extra pulses.
    always @(negedge clock) begin
        if (packet_size_valid) seen_pulses <= seen_pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [7:0] b);
        control = 1'b1;
        data    = b;
        @(posedge clock);
        #1;
    endtask

    task automatic gap;
        control = 1'b0;
        data    = 8'h00;
        @(posedge clock);
        #1;
    endtask

    task automatic send_header(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] tl, input bit bad_pre,
                               input logic [3:0] exp_flags);
        for (int i = 0; i < 8; i++) put((bad_pre && i == 3) ? 8'h54 : 8'h55);
        check_val("pre_flag", preamble_valid, exp_flags[3]);
        for (int i = 0; i < 6; i++) put(dst[47-8*i -: 8]);
        check_val("dst_flag", dst_addr_valid, exp_flags[2]);
        for (int i = 0; i < 6; i++) put(src[47-8*i -: 8]);
        check_val("src_flag", src_addr_valid, exp_flags[1]);
        put(tl[15:8]);
        put(tl[7:0]);
        check_val("tl_flag", type_length_valid, exp_flags[0]);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] tl, input int pay_len, input bit bad_pre,
                              input logic [3:0] exp_flags, input bit exp_good);
        send_header(dst, src, tl, bad_pre, exp_flags);
        for (int i = 0; i < pay_len; i++) put(8'h55);
        check_val("flags_held",
                  {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid},
                  exp_flags);
        gap();
        if (exp_good) begin
            exp_cnt = exp_cnt + 4'd1;
            exp_pulses++;
        end
        check_val("pulse", packet_size_valid, exp_good);
        check_val("counter", valid_packet_counter, exp_cnt);
        check_val("flags_clr",
                  {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid}, 0);
    endtask

    initial begin
        reset   = 1'b1;
        control = 1'b0;
        data    = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_pre", preamble_valid, 0);
        check_val("rst_dst", dst_addr_valid, 0);
        check_val("rst_src", src_addr_valid, 0);
        check_val("rst_tl", type_length_valid, 0);
        check_val("rst_pulse", packet_size_valid, 0);
        check_val("rst_cnt", valid_packet_counter, 0);
        reset = 1'b0;
        gap();

        // Nominal 64-byte frame, then confirm the pulse lasts a single cycle.
        send_frame(DST_OK, SRC_OK, 16'h0800, 50, 1'b0, 4'b1111, 1'b1);
        gap();
        check_val("pulse_1cyc", packet_size_valid, 0);

        send_frame(DST_OK, SRC_OK, 16'h0800, 49, 1'b0, 4'b1111, 1'b0);   // runt, 63 bytes
        send_frame(DST_OK, SRC_OK, 16'h0800, 50, 1'b1, 4'b0000, 1'b0);   // bad preamble
        send_frame(DST_OK, SRC_OK, 16'h0800, 50, 1'b0, 4'b1111, 1'b1);
        send_frame(ZERO48, SRC_OK, 16'h0800, 50, 1'b0, 4'b1000, 1'b0);
        send_frame(DST_OK, ONES48, 16'h0800, 50, 1'b0, 4'b1100, 1'b0);
        send_frame(DST_OK, ZERO48, 16'h0800, 50, 1'b0, 4'b1100, 1'b0);
        send_frame(DST_OK, SRC_OK, 16'h05DD, 50, 1'b0, 4'b1110, 1'b0);   // 1501
        send_frame(DST_OK, SRC_OK, 16'h05FF, 50, 1'b0, 4'b1110, 1'b0);   // 1535
        send_frame(DST_OK, SRC_OK, 16'h0600, 50, 1'b0, 4'b1111, 1'b1);   // 1536
        send_frame(DST_OK, SRC_OK, 16'h05DC, 1500, 1'b0, 4'b1111, 1'b1); // length 1500

        // Abort in the middle of SRC.
        for (int i = 0; i < 8; i++) put(8'h55);
        for (int i = 0; i < 6; i++) put(DST_OK[47-8*i -: 8]);
        for (int i = 0; i < 3; i++) put(8'hA0);
        check_val("abort_hdr", {preamble_valid, dst_addr_valid, src_addr_valid}, 3'b110);
        gap();
        check_val("abort_flags",
                  {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid}, 0);
        check_val("abort_pulse", packet_size_valid, 0);
        check_val("abort_cnt", valid_packet_counter, exp_cnt);

        send_frame(DST_OK, SRC_OK, 16'h0800, 1504, 1'b0, 4'b1111, 1'b1); // 1518 bytes
        send_frame(DST_OK, SRC_OK, 16'h0800, 1505, 1'b0, 4'b1111, 1'b0); // 1519 bytes

        // Reset during payload clears everything, counter included.
        send_header(DST_OK, SRC_OK, 16'h0800, 1'b0, 4'b1111);
        for (int i = 0; i < 10; i++) put(8'h55);
        reset = 1'b1;
        put(8'h55);
        check_val("midrst_out",
                  {preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid,
                   packet_size_valid, valid_packet_counter}, 0);
        reset = 1'b0;
        exp_cnt = 4'd0;
        gap();
        check_val("midrst_pulse", packet_size_valid, 0);

        // Sixteen back-to-back good frames with one idle cycle between them.
        for (int k = 0; k < 16; k++) begin
            send_frame(DST_OK, SRC_OK, 16'h0800, 50, 1'b0, 4'b1111, 1'b1);
            if (k == 14) check_val("cnt_15", valid_packet_counter, 15);
        end
        check_val("cnt_wrap", valid_packet_counter, 0);
        gap();
        check_val("pulse_total", seen_pulses, exp_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/epd_fsm.md
Name: epd_fsm

Overview:
Ethernet packet detector. Sits on a byte-wide receive stream qualified by `control`, one byte per clock.
- Parses preamble, destination address, source address, type/length and payload.
- Flags each field as valid once it has been received and checked.
- Counts complete, well-formed frames.

Parameters:
PREAMBLE_LEN, 8, number of preamble bytes; each must equal 0x55
MIN_FRAME, 64, minimum frame bytes (DST through last payload byte)
MAX_FRAME, 1518, maximum frame bytes (DST through last payload byte)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
data  in  8  receive byte, sampled on each rising clock edge while control=1
control  in  1  frame enable; high for the whole frame, low between frames
preamble_valid  out  1  PREAMBLE_LEN bytes of 0x55 received
dst_addr_valid  out  1  6 DST bytes received, DST != 00:00:00:00:00:00
src_addr_valid  out  1  6 SRC bytes received, SRC not all-zero and not FF:FF:FF:FF:FF:FF
type_length_valid  out  1  2 T/L bytes received (MSB first), value <=1500 or >=1536
packet_size_valid  out  1  one-cycle pulse: frame ended with all fields valid and size in range
valid_packet_counter  out  4  count of good frames, wraps 15->0

Behaviour:
- Reset: synchronous, active-high; only clock and reset are fixed by the interface decision. All outputs registered and 0 after reset; FSM goes to IDLE; byte counters cleared. Reset mid-frame aborts without counting.
- States and transitions:
  - IDLE: stays while control=0. Control=1 with data=0x55 goes to PRE (counts byte 1). Control=1 with another byte goes to ERR.
  - PRE: each byte must be 0x55, else ERR. On byte PREAMBLE_LEN, set preamble_valid and go to DST.
  - DST: 6 bytes, shift into a 48-bit register. After byte 6, set dst_addr_valid if non-zero, else go to ERR.
  - SRC: 6 bytes, same handling with the SRC rule.
  - TL: 2 bytes. Set type_length_valid if the value is not in 1501..1535, else ERR.
  - PAY: count bytes while control=1.
  - ERR: ignore data until control=0, then IDLE. No pulse, no count.
- Frame size counter: 11 bits, saturating at 2047. Counts DST+SRC+TL+payload bytes (preamble excluded).
- Control falling:
  - First cycle with control=0 while in PAY: if MIN_FRAME <= size <= MAX_FRAME, pulse packet_size_valid for exactly one cycle and increment valid_packet_counter on that same edge. Return to IDLE either way.
  - control=0 in PRE/DST/SRC/TL: abort to IDLE, no pulse.
- Field valid flags: each rises on the edge after its last byte is sampled. Held high until the FSM returns to IDLE, then all cleared together on that edge.
- A new frame may start on the cycle immediately after control returns to 0 for one cycle.
- Counter wraps modulo 16; no overflow flag.

Optional Feature:
Macro EPD_LENGTH_CHECK_EN.
- Defined: when type/length <=1500 (length field), payload byte count must be >= that value; otherwise no pulse and no count. Payload padding beyond the value is allowed.
- Undefined: the type/length value is only range-checked as above.

Decomposition:
- Package epd_pkg holds:
  - the state enum (IDLE, PRE, DST, SRC, TL, PAY, ERR);
  - constants PREAMBLE_BYTE=0x55, ADDR_BYTES=6, TL_BYTES=2, MAX_LENGTH=1500, MIN_TYPE=1536.
- Sub-module epd_field_shift: generic N-byte shift/capture register with byte counter and done flag, reused for DST, SRC and TL.

Test Plan:
- Nominal frame: 8x0x55, DST 01..06, SRC FF,FE,FD,FC,FB,FA, TL 0x0800, 50x0x55 payload, then control=0 -> all four field flags high in turn; packet_size_valid pulses once (size 64); counter 0->1.
- Runt frame: same headers with 49 payload bytes -> packet_size_valid stays 0; counter unchanged.
- Bad preamble: byte 4 = 0x54 -> preamble_valid never rises, ERR until control=0, no count; next good frame counts.
- Header errors:
  - DST all-zero -> dst_addr_valid 0, no count.
  - SRC FF:FF:FF:FF:FF:FF -> no count.
  - TL 0x05DD (1501) -> type_length_valid 0, no count.
- Mid-operation events:
  - control drops during SRC -> abort, flags cleared, no count.
  - reset asserted during PAY -> all outputs 0 next cycle.
- Wrap and back-to-back: 16 back-to-back good frames with a 1-cycle gap -> counter 15 then 0; oversize 1519-byte frame -> no count.
